// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA arithmetic blocks: the Montgomery
// multiplier state encoding.
package rsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mmm_core.sv
// Bit-serial radix-2 Montgomery multiplier: p = a*b*2^-WIDTH mod m, one bit of
// a per enabled cycle, followed by a single conditional subtraction.
module mmm_core
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done
);

    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam int              AW   = WIDTH + 2;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;

    logic [AW-1:0]    sum_u;
    logic [AW-1:0]    sum_red;

    // acc < 2*m on entry, so the difference always fits back into WIDTH bits.
    function automatic logic [WIDTH-1:0] final_sub(input logic [AW-1:0] acc_v,
                                                   input logic [WIDTH-1:0] m_v);
        logic [AW-1:0] m_ext;
        logic [AW-1:0] r;
        m_ext = {2'b00, m_v};
        r     = (acc_v >= m_ext) ? (acc_v - m_ext) : acc_v;
        return WIDTH'(r);
    endfunction

    always_comb begin
        sum_u   = acc_q + (a_sh_q[0] ? {2'b00, b_q} : '0);
        // Adding m when u is odd makes the sum even, so the shift is exact.
        sum_red = sum_u + (sum_u[0] ? {2'b00, m_q} : '0);
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_d     = b_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_d  = a;
                        b_d     = b;
                        m_d     = m;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    acc_d  = sum_red >> 1;
                    a_sh_d = a_sh_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = SUB;
                    end
                end
                SUB: begin
                    p_d     = final_sub(acc_q, m_q);
                    state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_q     <= b_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign p    = p_q;
    assign busy = (state_q == CALC) || (state_q == SUB);
    assign done = (state_q == DONE);

endmodule

// File: doc/mmm_core.md
# mmm_core

Self-contained bit-serial radix-2 Montgomery modular multiplier. It computes p = a·b·2^-WIDTH mod m and is the arithmetic stage consumed by the RSA exponentiation control FSM, which issues one multiplication per MAP, MMM or REMAP phase. Operands are latched on a start handshake, processed one bit of a per enabled cycle, and reduced by a single final conditional subtraction. A one-cycle done pulse marks a valid result.

## Interface
Parameters:
- WIDTH, 8, operand and modulus width in bits.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rstb  input  1  reset; one clock, reset is synchronous and active-low.
- ena  input  1  global enable; 0 freezes all state.
- start  input  1  request a multiplication; sampled only in IDLE.
- a  input  WIDTH  multiplicand, consumed LSB first; a < m.
- b  input  WIDTH  multiplier; b < m.
- m  input  WIDTH  modulus; must be odd.
- p  output  WIDTH  result register; holds its value until the next completion.
- busy  output  1  high in CALC and SUB.
- done  output  1  high for exactly one cycle, in DONE.

## Operation
- Registers:
  - a_sh (WIDTH), b_q (WIDTH), m_q (WIDTH), acc (WIDTH+2, unsigned).
  - cnt, with $clog2(WIDTH)+1 bits.
  - p (WIDTH), state.
- Reset (rstb=0 at an edge, regardless of ena): state=IDLE, all registers 0, so p=0, busy=0, done=0.
- ena=0 at an edge: every register holds, including state, cnt and p. done/busy stay as decoded from the held state.
- States and transitions:
  - IDLE: if start=1, latch a_sh=a, b_q=b, m_q=m, acc=0, cnt=0, then go to CALC. Otherwise stay.
  - CALC: one iteration per edge.
    - u = acc + (a_sh[0] ? b_q : 0); q = u[0]; acc ← (u + (q ? m_q : 0)) >> 1.
    - a_sh ← a_sh >> 1; cnt ← cnt+1.
    - When cnt == WIDTH-1 at the edge, go to SUB.
  - SUB: p ← (acc ≥ m_q) ? acc − m_q : acc, truncated to WIDTH bits. Go to DONE.
  - DONE: done=1; go to IDLE on the next enabled edge.
- Arithmetic invariant: acc < 2·m_q after every iteration. WIDTH+2 bits is enough for u + m_q with no overflow. After SUB, p < m.
- start is ignored in CALC, SUB and DONE; there is no queueing. Changing a, b or m after the start edge has no effect.
- Inputs that violate a<m, b<m or m odd give an unspecified p, but the FSM timing is unchanged.

## Timing
- Start sampled at edge E0. CALC occupies edges E1..EWIDTH, SUB executes at EWIDTH+1, and done is high in the cycle after EWIDTH+1.
- Latency from the start cycle to the done cycle is WIDTH+2 enabled cycles. Each ena=0 cycle stretches it by one.
- busy rises in the cycle after E0 and falls as done rises.
- The earliest back-to-back start is the cycle after done (IDLE). Throughput is one result per WIDTH+3 cycles.
- rstb low mid-operation aborts at that edge: state IDLE, p=0, no done pulse.
- start held high continuously restarts on every IDLE visit.

## Structure
- Shared package rsa_pkg: the state enum typedef (IDLE, CALC, SUB, DONE), 2 bits.
- No sub-module. The datapath (adder pair, comparator/subtractor) and the counter are inline in mmm_core, at about 150–200 RTL lines.

## Test plan
All cases use WIDTH=8, m=239, and 2^-8 mod 239 = 225.
- Identity: a=1, b=1 → p=225, done exactly 10 cycles after the start cycle, busy high for 9 cycles.
- Montgomery form: a=17, b=1 → p=1. Then a=17, b=17 → p=17, issued back-to-back with start held high.
- Max operands with final subtraction: a=238, b=238 → p=225. Zero: a=0, b=200 → p=0. Confirm p never ≥ 239.
- ena gating: drop ena for 3 cycles mid-CALC → p=225 (for a=b=1) with done delayed exactly 3 cycles. Confirm done stays high while ena=0 in DONE.
- Reset mid-operation: assert rstb=0 at the 4th CALC cycle → next cycle busy=0, done=0, p=0. A fresh start then completes normally.
- Randomized check against a reference model a·b·225 mod 239, with start pulses during busy → those pulses are ignored and the result is unchanged.
